// File: rtl/bfp16_col_feeder.sv
// bfp16_col_feeder: collects LANES weights, shifts them into the column (ctrl=0), then streams diagonally skewed ifmap rows (ctrl=1) and drains the skew.
// Latency: weight[0] appears 2 cycles after the last weight handshake; ifmap lane l appears l+1 cycles after its row handshake; done coincides with the last lane of the final row.
// Backpressure: w_ready/row_ready are registered phase indicators; emission and drain never stall, and bubbles in row_valid become zero rows.
module bfp16_col_feeder #(
   parameter int DATA_TYPE = 16,
   parameter int LANES     = 8,   // at least 2: the drain phase is LANES-1 cycles long
   parameter int ROW_W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [ROW_W-1:0]           num_rows,
   input  logic                       w_valid,
   input  logic [DATA_TYPE-1:0]       w_data,
   output logic                       w_ready,
   input  logic                       row_valid,
   input  logic [LANES*DATA_TYPE-1:0] row_data,
   output logic                       row_ready,
   output logic                       ctrl,
   output logic [DATA_TYPE-1:0]       weight,
   output logic [LANES*DATA_TYPE-1:0] ifmap,
   output logic                       busy,
   output logic                       done
);

   localparam int            CW         = $clog2(LANES);
   localparam logic [CW-1:0] LAST       = CW'(LANES - 1);
   localparam logic [CW-1:0] DRAIN_LAST = CW'(LANES - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT_W,
      S_EMIT_W,
      S_STREAM,
      S_DRAIN
   } state_t;

   state_t                     state_q, state_d;
   logic [CW-1:0]              cnt_q, cnt_d;        // weight index while collecting/emitting, drain cycle count
   logic [ROW_W-1:0]           rcnt_q, rcnt_d;
   logic [ROW_W-1:0]           nrows_q, nrows_d;
   logic [DATA_TYPE-1:0]       wbuf_q [LANES];

   logic                       w_ready_q, w_ready_d;
   logic                       row_ready_q, row_ready_d;
   logic                       ctrl_q, ctrl_d;
   logic [DATA_TYPE-1:0]       weight_q, weight_d;
   logic [LANES*DATA_TYPE-1:0] ifmap_q;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic                       w_hs;
   logic                       r_hs;
   logic [LANES*DATA_TYPE-1:0] stage_in;   // accepted row, or an all-zero bubble
   logic [LANES*DATA_TYPE-1:0] lane_dly;   // each lane already delayed by its own index

   assign w_hs     = w_valid & w_ready_q;
   assign r_hs     = row_valid & row_ready_q;
   assign stage_in = r_hs ? row_data : '0;

   // Next-state and registered-output decode; ready/busy follow the next state so they line up with it.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rcnt_d   = rcnt_q;
      nrows_d  = nrows_q;
      ctrl_d   = 1'b0;
      weight_d = '0;
      done_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start && (num_rows != '0)) begin
               nrows_d = num_rows;
               cnt_d   = '0;
               rcnt_d  = '0;
               state_d = S_COLLECT_W;
            end
         end
         S_COLLECT_W: begin
            if (w_hs) begin
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = S_EMIT_W;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_EMIT_W: begin
            weight_d = wbuf_q[cnt_q];
            if (cnt_q == LAST) begin
               cnt_d   = '0;
               state_d = S_STREAM;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_STREAM: begin
            ctrl_d = 1'b1;
            if (r_hs) begin
               if (rcnt_q == nrows_q - 1'b1) begin
                  cnt_d   = '0;
                  state_d = S_DRAIN;
               end else begin
                  rcnt_d = rcnt_q + 1'b1;
               end
            end
         end
         S_DRAIN: begin
            ctrl_d = 1'b1;
            if (cnt_q == DRAIN_LAST) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      w_ready_d   = (state_d == S_COLLECT_W);
      row_ready_d = (state_d == S_STREAM);
      busy_d      = (state_d != S_IDLE);
   end

   // State, counters and all output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         rcnt_q      <= '0;
         nrows_q     <= '0;
         w_ready_q   <= 1'b0;
         row_ready_q <= 1'b0;
         ctrl_q      <= 1'b0;
         weight_q    <= '0;
         ifmap_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rcnt_q      <= rcnt_d;
         nrows_q     <= nrows_d;
         w_ready_q   <= w_ready_d;
         row_ready_q <= row_ready_d;
         ctrl_q      <= ctrl_d;
         weight_q    <= weight_d;
         ifmap_q     <= lane_dly;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Weight buffer, filled in arrival order and read back in the same order.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LANES; i++) wbuf_q[i] <= '0;
      end else if (w_hs) begin
         wbuf_q[cnt_q] <= w_data;
      end
   end

   // Diagonal skew: lane l passes through l delay stages ahead of the output register.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      if (l == 0) begin : g_direct
         assign lane_dly[DATA_TYPE-1:0] = stage_in[DATA_TYPE-1:0];
      end else begin : g_sr
         logic [DATA_TYPE-1:0] sr_q [l];
         // Per-lane delay line; zero bubbles keep it flushing between jobs.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < l; k++) sr_q[k] <= '0;
            end else begin
               sr_q[0] <= stage_in[l*DATA_TYPE +: DATA_TYPE];
               for (int k = 1; k < l; k++) sr_q[k] <= sr_q[k-1];
            end
         end
         assign lane_dly[l*DATA_TYPE +: DATA_TYPE] = sr_q[l-1];
      end
   end

   assign w_ready   = w_ready_q;
   assign row_ready = row_ready_q;
   assign ctrl      = ctrl_q;
   assign weight    = weight_q;
   assign ifmap     = ifmap_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_bfp16_col_feeder.sv
// tb_bfp16_col_feeder: drives an 8-lane and a 4-lane feeder; the 8-lane one is compared every cycle
// against an event-timed reference model (job start, last weight, last row), the 4-lane one by hand.
module tb_bfp16_col_feeder;
   localparam int L    = 8;
   localparam int DW   = 16;
   localparam int NONE = 1 << 28;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start, w_valid, w_ready, row_valid, row_ready, ctrl, busy, done;
   logic [7:0]   num_rows;
   logic [15:0]  w_data, weight;
   logic [127:0] row_data, ifmap;

   logic         start4, w_valid4, w_ready4, row_valid4, row_ready4, ctrl4, busy4, done4;
   logic [7:0]   num_rows4;
   logic [15:0]  w_data4, weight4;
   logic [63:0]  row_data4, ifmap4;

   bfp16_col_feeder #(.DATA_TYPE(16), .LANES(8), .ROW_W(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
      .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
      .row_valid(row_valid), .row_data(row_data), .row_ready(row_ready),
      .ctrl(ctrl), .weight(weight), .ifmap(ifmap), .busy(busy), .done(done));

   bfp16_col_feeder #(.DATA_TYPE(16), .LANES(4), .ROW_W(8)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .num_rows(num_rows4),
      .w_valid(w_valid4), .w_data(w_data4), .w_ready(w_ready4),
      .row_valid(row_valid4), .row_data(row_data4), .row_ready(row_ready4),
      .ctrl(ctrl4), .weight(weight4), .ifmap(ifmap4), .busy(busy4), .done(done4));

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   // ---------------- reference model for the 8-lane instance ----------------
   bit           mon_en = 1'b0;
   logic [127:0] rows_at [int];    // accepted rows keyed by handshake cycle
   logic [15:0]  wq [L];
   bit           m_active = 1'b0;
   int           m_s, m_wlast, m_rlast, m_n, m_wc, m_rc;
   int           ctrl1_cnt, wemit_cnt, done_cnt;

   always @(negedge clk) begin
      int           t;
      logic         e_wr, e_rr, e_ctrl, e_done, e_busy;
      logic [15:0]  e_w;
      logic [127:0] e_if, tmp;
      if (mon_en) begin
         t      = cyc;
         e_wr   = m_active && t > m_s && t <= m_wlast;
         e_rr   = m_active && t >= m_wlast + L + 1 && t <= m_rlast;
         e_ctrl = m_active && t >= m_wlast + L + 2 && t <= m_rlast + L;
         e_done = m_active && t == m_rlast + L;
         e_busy = m_active && t > m_s && t < m_rlast + L;
         e_w    = 16'h0;
         if (m_active && t >= m_wlast + 2 && t <= m_wlast + L + 1) e_w = wq[t - m_wlast - 2];
         e_if = '0;
         for (int l = 0; l < L; l++) begin
            if (rows_at.exists(t - 1 - l)) begin
               tmp = rows_at[t - 1 - l];
               e_if[l*DW +: DW] = tmp[l*DW +: DW];
            end
         end
         chk("w_ready", w_ready, e_wr);
         chk("row_ready", row_ready, e_rr);
         chk("ctrl", ctrl, e_ctrl);
         chk("done", done, e_done);
         chk("busy", busy, e_busy);
         chk("weight", weight, e_w);
         chk("ifmap", ifmap, e_if);
         if (ctrl) ctrl1_cnt++;
         if (!ctrl && weight != 16'h0) wemit_cnt++;
         if (done) done_cnt++;
         if (rst) begin
            m_active = 1'b0;
            rows_at.delete();
         end else begin
            if (start && num_rows != 8'd0 && (!m_active || t >= m_rlast + L)) begin
               m_active = 1'b1; m_s = t; m_wlast = NONE; m_rlast = NONE;
               m_n = int'(num_rows); m_wc = 0; m_rc = 0;
            end
            if (w_valid && e_wr) begin
               wq[m_wc] = w_data;
               m_wc++;
               if (m_wc == L) m_wlast = t;
            end
            if (row_valid && e_rr) begin
               rows_at[t] = row_data;
               m_rc++;
               if (m_rc == m_n) m_rlast = t;
            end
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_counts();
      ctrl1_cnt = 0; wemit_cnt = 0; done_cnt = 0;
   endtask

   task automatic do_start(input logic [7:0] n);
      start = 1'b1; num_rows = n;
      tick();
      start = 1'b0;
   endtask

   task automatic send_word(input logic [15:0] d, input bit gap);
      int k = 0;
      w_valid = 1'b1; w_data = d;
      while (!w_ready && k < 40) begin tick(); k++; end
      chk("w_ready before weight handshake", w_ready, 1'b1);
      tick();
      w_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic send_row(input logic [127:0] d, input bit gap);
      int k = 0;
      row_valid = 1'b1; row_data = d;
      while (!row_ready && k < 40) begin tick(); k++; end
      chk("row_ready before row handshake", row_ready, 1'b1);
      tick();
      row_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic wait_done(input int budget);
      int k = 0;
      while (!done && k < budget) begin tick(); k++; end
      chk("done reached", done, 1'b1);
      tick();
   endtask

   function automatic logic [127:0] rand_row();
      logic [127:0] r;
      for (int l = 0; l < L; l++) r[l*DW +: DW] = 16'($urandom);
      return r;
   endfunction

   typedef struct {
      bit         st;
      logic [7:0] nr;
      bit         e_busy;
      bit         e_wr;
   } tv_t;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tv_t         tv [5];
      logic [15:0] vals4 [4];
      logic [63:0] exp4;
      int          n, k;

      tv[0] = '{st: 1'b0, nr: 8'd5, e_busy: 1'b0, e_wr: 1'b0};   // no start
      tv[1] = '{st: 1'b1, nr: 8'd0, e_busy: 1'b0, e_wr: 1'b0};   // zero rows ignored
      tv[2] = '{st: 1'b1, nr: 8'd2, e_busy: 1'b1, e_wr: 1'b1};   // accepted
      tv[3] = '{st: 1'b1, nr: 8'd0, e_busy: 1'b1, e_wr: 1'b1};   // ignored while busy
      tv[4] = '{st: 1'b1, nr: 8'd7, e_busy: 1'b1, e_wr: 1'b1};   // ignored while busy
      vals4 = '{16'h4000, 16'h3F80, 16'h4040, 16'h4080};

      rst = 1'b1; start = 1'b0; num_rows = '0; w_valid = 1'b0; w_data = '0;
      row_valid = 1'b0; row_data = '0;
      start4 = 1'b0; num_rows4 = '0; w_valid4 = 1'b0; w_data4 = '0;
      row_valid4 = 1'b0; row_data4 = '0;
      repeat (3) tick();

      chk("reset ctrl", ctrl, 1'b0);
      chk("reset weight", weight, 16'h0);
      chk("reset ifmap", ifmap, 128'h0);
      chk("reset w_ready", w_ready, 1'b0);
      chk("reset row_ready", row_ready, 1'b0);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset busy4", busy4, 1'b0);
      rst = 1'b0;
      mon_en = 1'b1;
      tick();

      // T1: uniform weights and rows, back-to-back
      clr_counts();
      do_start(8'd4);
      for (int i = 0; i < L; i++) send_word(16'h3F80, 1'b0);
      for (int i = 0; i < 4; i++) send_row({8{16'h3F80}}, 1'b0);
      wait_done(40);
      chk("T1 ctrl=1 cycles", ctrl1_cnt, 11);
      chk("T1 weight emit cycles", wemit_cnt, 8);
      chk("T1 done pulses", done_cnt, 1);

      // T2: ascending weights with w_valid toggling
      clr_counts();
      do_start(8'd1);
      for (int i = 0; i < L; i++) send_word(16'h3F80 + 16'(i), 1'b1);
      send_row(rand_row(), 1'b0);
      wait_done(40);
      chk("T2 weight emit cycles", wemit_cnt, 8);
      chk("T2 done pulses", done_cnt, 1);

      // T3: two-cycle bubble between the first and second row
      clr_counts();
      do_start(8'd3);
      for (int i = 0; i < L; i++) send_word(16'h4000 + 16'(i), 1'b0);
      send_row({8{16'h1111}}, 1'b0);
      tick(); tick();
      send_row({8{16'h2222}}, 1'b0);
      send_row({8{16'h3333}}, 1'b0);
      wait_done(40);
      chk("T3 ctrl=1 cycles", ctrl1_cnt, 12);
      chk("T3 done pulses", done_cnt, 1);

      // T4: reset in STREAM after two rows, then a fresh job
      clr_counts();
      do_start(8'd4);
      for (int i = 0; i < L; i++) send_word(16'($urandom), 1'b0);
      send_row(rand_row(), 1'b0);
      send_row(rand_row(), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("T4 ctrl after reset", ctrl, 1'b0);
      chk("T4 busy after reset", busy, 1'b0);
      chk("T4 row_ready after reset", row_ready, 1'b0);
      chk("T4 ifmap after reset", ifmap, 128'h0);
      repeat (20) tick();
      chk("T4 no done after reset", done_cnt, 0);
      do_start(8'd2);
      for (int i = 0; i < L; i++) send_word(16'($urandom), 1'b0);
      send_row(rand_row(), 1'b0);
      send_row(rand_row(), 1'b1);
      wait_done(40);
      chk("T4 fresh job done pulses", done_cnt, 1);

      // T5: start gating table
      clr_counts();
      for (int i = 0; i < 5; i++) begin
         start = tv[i].st; num_rows = tv[i].nr;
         tick();
         start = 1'b0;
         chk("T5 busy", busy, tv[i].e_busy);
         chk("T5 w_ready", w_ready, tv[i].e_wr);
      end
      for (int i = 0; i < L; i++) send_word(16'($urandom), 1'b0);
      send_row(rand_row(), 1'b0);
      send_row(rand_row(), 1'b0);
      repeat (2) tick();
      chk("T5 row_ready after latched count", row_ready, 1'b0);
      wait_done(40);
      chk("T5 done pulses", done_cnt, 1);

      // T6: randomized jobs with gaps and handshake noise outside the active phase
      for (int j = 0; j < 8; j++) begin
         n = $urandom_range(1, 6);
         do_start(8'(n));
         row_valid = 1'($urandom); row_data = rand_row();
         for (int i = 0; i < L; i++) send_word(16'($urandom), 1'($urandom));
         w_valid = 1'($urandom); w_data = 16'($urandom);
         for (int i = 0; i < n; i++) send_row(rand_row(), 1'($urandom));
         w_valid = 1'($urandom);
         wait_done(60);
         w_valid = 1'b0;
         repeat ($urandom_range(0, 3)) tick();
      end

      // T7: 4-lane build, single row
      start4 = 1'b1; num_rows4 = 8'd1;
      tick();
      start4 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         w_valid4 = 1'b1; w_data4 = 16'h1000 + 16'(i);
         k = 0;
         while (!w_ready4 && k < 20) begin tick(); k++; end
         chk("L4 w_ready", w_ready4, 1'b1);
         tick();
         w_valid4 = 1'b0;
      end
      tick();
      chk("L4 first weight", weight4, 16'h1000);
      row_valid4 = 1'b1;
      row_data4  = {vals4[3], vals4[2], vals4[1], vals4[0]};
      k = 0;
      while (!row_ready4 && k < 20) begin tick(); k++; end
      chk("L4 row_ready", row_ready4, 1'b1);
      tick();
      row_valid4 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         exp4 = '0;
         exp4[c*16 +: 16] = vals4[c];
         chk("L4 ifmap skew", ifmap4, exp4);
         chk("L4 done timing", done4, c == 3);
         chk("L4 ctrl", ctrl4, 1'b1);
         tick();
      end
      chk("L4 ifmap after job", ifmap4, 64'h0);
      chk("L4 ctrl after job", ctrl4, 1'b0);
      chk("L4 busy after job", busy4, 1'b0);
      chk("L4 done single pulse", done4, 1'b0);

      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
